conv1d_stream_engine: RTL and testbench

Runtime-configurable 1D convolution layer engine for the OFDM CWGAN-GP generator and critic datapath.
- Shape is latched at start: frame length, channels, kernel, stride, padding.
- Loads one channel-major frame, then computes each output sample with a sequential MAC over in_ch×kernel.
- Bias, optional LeakyReLU and Q8.8 saturation are fused at the end of each sample.
- Outputs stream with valid/ready backpressure, so no output buffer is needed.

---
 rtl/conv1d_stream_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 tb/tb_conv1d_stream_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_engine.sv
// ---------------------------------------------------------------------------
// conv1d_stream_engine
//
// Runtime-configurable 1D convolution layer engine for the OFDM CWGAN-GP
// generator/critic datapath.
//
// Flow:
// - The shape is latched on start.
// - One channel-major frame is loaded into a local buffer.
// - Each output sample is produced by a sequential MAC over in_ch x kernel.
// - Bias, optional LeakyReLU and Q8.8 saturation are applied at the end.
// - The sample is streamed out with valid/ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               start pulse (sampled only in IDLE)
//   cfg_*               frame length, channels, kernel, stride, padding, act
//   s_data/s_valid/s_ready       channel-major input stream
//   weight_addr/weight_data      weight ROM port, data one cycle after address
//   bias_addr/bias_data          bias ROM port, data one cycle after address
//   m_data/m_valid/m_ready/m_last  output stream, oc-major then position
//   busy, done, cfg_err           status
// ---------------------------------------------------------------------------
module conv1d_stream_engine #(
  parameter int DATA_WIDTH    = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int WEIGHT_FRAC   = 7,
  parameter int MAX_FRAME_LEN = 64,
  parameter int MAX_IN_CH     = 8,
  parameter int MAX_OUT_CH    = 16,
  parameter int MAX_KERNEL    = 7,
  parameter int LEAKY_SHIFT   = 3
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               start,
  input  logic [$clog2(MAX_FRAME_LEN+1)-1:0]                 cfg_frame_len,
  input  logic [$clog2(MAX_IN_CH+1)-1:0]                     cfg_in_ch,
  input  logic [$clog2(MAX_OUT_CH+1)-1:0]                    cfg_out_ch,
  input  logic [$clog2(MAX_KERNEL+1)-1:0]                    cfg_kernel,
  input  logic [1:0]                                         cfg_stride,
  input  logic [$clog2(MAX_KERNEL)-1:0]                      cfg_padding,
  input  logic                                               cfg_act,
  input  logic [DATA_WIDTH-1:0]                              s_data,
  input  logic                                               s_valid,
  output logic                                               s_ready,
  output logic [$clog2(MAX_OUT_CH*MAX_IN_CH*MAX_KERNEL)-1:0] weight_addr,
  input  logic [WEIGHT_WIDTH-1:0]                            weight_data,
  output logic [$clog2(MAX_OUT_CH)-1:0]                      bias_addr,
  input  logic [DATA_WIDTH-1:0]                              bias_data,
  output logic [DATA_WIDTH-1:0]                              m_data,
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic                                               m_last,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               cfg_err
);

  localparam int FL_W      = $clog2(MAX_FRAME_LEN+1);
  localparam int IC_W      = $clog2(MAX_IN_CH+1);
  localparam int OC_W      = $clog2(MAX_OUT_CH+1);
  localparam int K_W       = $clog2(MAX_KERNEL+1);
  localparam int P_W       = $clog2(MAX_KERNEL);
  localparam int WA_W      = $clog2(MAX_OUT_CH*MAX_IN_CH*MAX_KERNEL);
  localparam int BA_W      = $clog2(MAX_OUT_CH);
  localparam int BUF_DEPTH = MAX_IN_CH*MAX_FRAME_LEN;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);
  localparam int OP_W      = $clog2(MAX_FRAME_LEN+2*MAX_KERNEL+1);
  localparam int IDX_W     = OP_W+3;
  localparam int CW        = FL_W+IC_W+OC_W+K_W;
  localparam int PROD_W    = DATA_WIDTH+WEIGHT_WIDTH;
  localparam int Y_W       = ACC_WIDTH+1;

  localparam logic [FL_W-1:0] FL_ONE = FL_W'(1);
  localparam logic [IC_W-1:0] IC_ONE = IC_W'(1);
  localparam logic [OC_W-1:0] OC_ONE = OC_W'(1);
  localparam logic [K_W-1:0]  K_ONE  = K_W'(1);
  localparam logic [OP_W-1:0] OP_ONE = OP_W'(1);

  // Saturation bounds of the Q8.8 output expressed at the wide result width
  localparam logic signed [Y_W-1:0] SAT_MAX = {{(Y_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [Y_W-1:0] SAT_MIN = {{(Y_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_POST  = 3'd4,
    ST_OUT   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t state_r;

  // Latched shape
  logic [FL_W-1:0] cfg_len_r;
  logic [IC_W-1:0] cfg_c_r;
  logic [OC_W-1:0] cfg_m_r;
  logic [K_W-1:0]  cfg_k_r;
  logic [1:0]      cfg_s_r;
  logic [P_W-1:0]  cfg_p_r;
  logic            cfg_act_r;
  logic [OP_W-1:0] o_len_r;

  // Sequencing counters
  logic [IC_W-1:0] load_ic_r;
  logic [FL_W-1:0] load_pos_r;
  logic [IC_W-1:0] mac_ic_r;
  logic [K_W-1:0]  mac_k_r;
  logic            flush_cnt_r;
  logic [OC_W-1:0] oc_r;
  logic [OP_W-1:0] op_r;

  // MAC pipeline: stage 1 waits for the weight, stage 2 multiplies
  logic                         v1_r, first1_r, v2_r, first2_r;
  logic [DATA_WIDTH-1:0]        x1_r, x2_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;

  // Registered outputs
  logic                  s_ready_r, m_valid_r, m_last_r, busy_r, done_r, cfg_err_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic [WA_W-1:0]       weight_addr_r;
  logic [BA_W-1:0]       bias_addr_r;

  logic [DATA_WIDTH-1:0] frame_buf_r [BUF_DEPTH];

  // Combinational helpers
  logic                        cfg_illegal_s;
  logic [CW-1:0]               span_s, kext_s, pext_s, diff_s;
  logic [OP_W-1:0]             o_len_s;
  logic [OP_W:0]               opx_s;
  logic signed [IDX_W-1:0]     idx_s;
  logic                        in_range_s;
  logic [BUF_AW-1:0]           rd_addr_s, wr_addr_s;
  logic [DATA_WIDTH-1:0]       x_issue_s;
  logic [WA_W-1:0]             waddr_s;
  logic signed [PROD_W-1:0]    prod_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s, shifted_s;
  logic signed [Y_W-1:0]       y_s, act_s;
  logic [DATA_WIDTH-1:0]       sat_s;

  assign s_ready     = s_ready_r;
  assign m_valid     = m_valid_r;
  assign m_last      = m_last_r;
  assign m_data      = m_data_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;
  assign weight_addr = weight_addr_r;
  assign bias_addr   = bias_addr_r;

  // Configuration legality and output length, evaluated on the raw cfg inputs
  always_comb begin
    span_s = CW'(cfg_frame_len) + (CW'(cfg_padding) << 1);
    kext_s = CW'(cfg_kernel);
    pext_s = CW'(cfg_padding);
    diff_s = span_s - kext_s;
    if (cfg_stride == 2'd2) begin
      o_len_s = OP_W'(diff_s >> 1) + OP_ONE;
    end else begin
      o_len_s = OP_W'(diff_s) + OP_ONE;
    end
    cfg_illegal_s = (kext_s == {CW{1'b0}}) || (kext_s > CW'(MAX_KERNEL)) ||
                    ((cfg_stride != 2'd1) && (cfg_stride != 2'd2)) ||
                    (CW'(cfg_in_ch) == {CW{1'b0}}) || (CW'(cfg_in_ch) > CW'(MAX_IN_CH)) ||
                    (CW'(cfg_out_ch) == {CW{1'b0}}) || (CW'(cfg_out_ch) > CW'(MAX_OUT_CH)) ||
                    (CW'(cfg_frame_len) == {CW{1'b0}}) || (CW'(cfg_frame_len) > CW'(MAX_FRAME_LEN)) ||
                    (pext_s >= kext_s) || (span_s < kext_s);
  end

  // Issue-side addressing: padded input index, buffer read and weight address
  always_comb begin
    if (cfg_s_r == 2'd2) begin
      opx_s = {op_r, 1'b0};
    end else begin
      opx_s = {1'b0, op_r};
    end
    idx_s = $signed(IDX_W'(opx_s)) + $signed(IDX_W'(mac_k_r)) - $signed(IDX_W'(cfg_p_r));
    in_range_s = (idx_s >= $signed({IDX_W{1'b0}})) && (idx_s < $signed(IDX_W'(cfg_len_r)));
    if (in_range_s) begin
      rd_addr_s = BUF_AW'(int'(mac_ic_r) * MAX_FRAME_LEN + int'(idx_s));
      x_issue_s = frame_buf_r[rd_addr_s];
    end else begin
      rd_addr_s = {BUF_AW{1'b0}};
      x_issue_s = {DATA_WIDTH{1'b0}};
    end
    waddr_s   = WA_W'((int'(oc_r) * int'(cfg_c_r) + int'(mac_ic_r)) * int'(cfg_k_r) + int'(mac_k_r));
    wr_addr_s = BUF_AW'(int'(load_ic_r) * MAX_FRAME_LEN + int'(load_pos_r));
  end

  // Full-precision product sign-extended to the accumulator width
  always_comb begin
    prod_s     = $signed(x2_r) * $signed(weight_data);
    prod_ext_s = {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  // Post-processing: drop weight fraction, add bias, LeakyReLU, saturate
  always_comb begin
    shifted_s = acc_r >>> WEIGHT_FRAC;
    y_s = $signed({shifted_s[ACC_WIDTH-1], shifted_s}) +
          $signed({{(Y_W-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data});
    if (cfg_act_r && y_s[Y_W-1]) begin
      act_s = y_s >>> LEAKY_SHIFT;
    end else begin
      act_s = y_s;
    end
    if (act_s > SAT_MAX) begin
      sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (act_s < SAT_MIN) begin
      sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_s = act_s[DATA_WIDTH-1:0];
    end
  end

  // Frame buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && s_valid && s_ready_r) begin
      frame_buf_r[wr_addr_s] <= s_data;
    end
  end

  // MAC pipeline: weight_data arrives one cycle after weight_addr, so the
  // buffer sample is delayed two stages to meet it; first term clears acc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r          <= 1'b0;
      first1_r      <= 1'b0;
      x1_r          <= {DATA_WIDTH{1'b0}};
      v2_r          <= 1'b0;
      first2_r      <= 1'b0;
      x2_r          <= {DATA_WIDTH{1'b0}};
      acc_r         <= {ACC_WIDTH{1'b0}};
      weight_addr_r <= {WA_W{1'b0}};
    end else begin
      v1_r     <= (state_r == ST_MAC);
      first1_r <= (state_r == ST_MAC) && (mac_ic_r == {IC_W{1'b0}}) && (mac_k_r == {K_W{1'b0}});
      x1_r     <= x_issue_s;
      v2_r     <= v1_r;
      first2_r <= first1_r;
      x2_r     <= x1_r;
      if (state_r == ST_MAC) begin
        weight_addr_r <= waddr_s;
      end
      if (v2_r) begin
        acc_r <= first2_r ? prod_ext_s : (acc_r + prod_ext_s);
      end
    end
  end

  // Control FSM with registered stream and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_len_r   <= {FL_W{1'b0}};
      cfg_c_r     <= {IC_W{1'b0}};
      cfg_m_r     <= {OC_W{1'b0}};
      cfg_k_r     <= {K_W{1'b0}};
      cfg_s_r     <= 2'd0;
      cfg_p_r     <= {P_W{1'b0}};
      cfg_act_r   <= 1'b0;
      o_len_r     <= {OP_W{1'b0}};
      load_ic_r   <= {IC_W{1'b0}};
      load_pos_r  <= {FL_W{1'b0}};
      mac_ic_r    <= {IC_W{1'b0}};
      mac_k_r     <= {K_W{1'b0}};
      flush_cnt_r <= 1'b0;
      oc_r        <= {OC_W{1'b0}};
      op_r        <= {OP_W{1'b0}};
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      m_data_r    <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      bias_addr_r <= {BA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            cfg_len_r   <= cfg_frame_len;
            cfg_c_r     <= cfg_in_ch;
            cfg_m_r     <= cfg_out_ch;
            cfg_k_r     <= cfg_kernel;
            cfg_s_r     <= cfg_stride;
            cfg_p_r     <= cfg_padding;
            cfg_act_r   <= cfg_act;
            o_len_r     <= o_len_s;
            cfg_err_r   <= cfg_illegal_s;
            load_ic_r   <= {IC_W{1'b0}};
            load_pos_r  <= {FL_W{1'b0}};
            mac_ic_r    <= {IC_W{1'b0}};
            mac_k_r     <= {K_W{1'b0}};
            oc_r        <= {OC_W{1'b0}};
            op_r        <= {OP_W{1'b0}};
            bias_addr_r <= {BA_W{1'b0}};
            if (cfg_illegal_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= ST_LOAD;
              s_ready_r <= 1'b1;
              busy_r    <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (s_valid && s_ready_r) begin
            if (load_pos_r == cfg_len_r - FL_ONE) begin
              load_pos_r <= {FL_W{1'b0}};
              if (load_ic_r == cfg_c_r - IC_ONE) begin
                s_ready_r <= 1'b0;
                state_r   <= ST_MAC;
              end else begin
                load_ic_r <= load_ic_r + IC_ONE;
              end
            end else begin
              load_pos_r <= load_pos_r + FL_ONE;
            end
          end
        end
        ST_MAC: begin
          if (mac_k_r == cfg_k_r - K_ONE) begin
            mac_k_r <= {K_W{1'b0}};
            if (mac_ic_r == cfg_c_r - IC_ONE) begin
              mac_ic_r    <= {IC_W{1'b0}};
              flush_cnt_r <= 1'b0;
              state_r     <= ST_FLUSH;
            end else begin
              mac_ic_r <= mac_ic_r + IC_ONE;
            end
          end else begin
            mac_k_r <= mac_k_r + K_ONE;
          end
        end
        ST_FLUSH: begin
          // Two drain cycles: last term reaches stage 2 and then the accumulator
          if (flush_cnt_r) begin
            state_r <= ST_POST;
          end else begin
            flush_cnt_r <= 1'b1;
          end
        end
        ST_POST: begin
          m_data_r  <= sat_s;
          m_valid_r <= 1'b1;
          m_last_r  <= (oc_r == cfg_m_r - OC_ONE) && (op_r == o_len_r - OP_ONE);
          state_r   <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            if (op_r == o_len_r - OP_ONE) begin
              op_r <= {OP_W{1'b0}};
              if (oc_r == cfg_m_r - OC_ONE) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
              end else begin
                oc_r        <= oc_r + OC_ONE;
                bias_addr_r <= BA_W'(oc_r + OC_ONE);
                state_r     <= ST_MAC;
              end
            end else begin
              op_r    <= op_r + OP_ONE;
              state_r <= ST_MAC;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for conv1d_stream_engine. Weight and bias
// ROMs are modelled with one-cycle read latency. Expected values are either
// hand-computed constants or come from a small reference convolution.
// ---------------------------------------------------------------------------
module tb_conv1d_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  cfg_frame_len = 7'd0;
  logic [3:0]  cfg_in_ch = 4'd0;
  logic [4:0]  cfg_out_ch = 5'd0;
  logic [2:0]  cfg_kernel = 3'd0;
  logic [1:0]  cfg_stride = 2'd0;
  logic [2:0]  cfg_padding = 3'd0;
  logic        cfg_act = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  weight_addr;
  logic [7:0]  weight_data;
  logic [3:0]  bias_addr;
  logic [15:0] bias_data;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy, done, cfg_err;

  conv1d_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_frame_len(cfg_frame_len), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride), .cfg_padding(cfg_padding),
    .cfg_act(cfg_act), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  wmem [0:895];
  logic [15:0] bmem [0:15];
  logic [15:0] in_mem [0:511];

  // ROMs with one-cycle read latency
  always @(posedge clk) begin
    weight_data <= wmem[weight_addr];
    bias_data   <= bmem[bias_addr];
  end

  int done_total = 0;
  int s_ready_total = 0;
  // Free-running event counters sampled mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) done_total = done_total + 1;
    if (s_ready === 1'b1) s_ready_total = s_ready_total + 1;
  end

  int errors = 0;
  int checks = 0;
  int c_L, c_C, c_M, c_K, c_S, c_P, c_act, c_O;
  logic [15:0] out_q[$];
  logic        last_q[$];

  function automatic logic [15:0] model_out(input int oc, input int op);
    longint acc, y, b;
    int x, w, idx;
    acc = 0;
    for (int ic = 0; ic < c_C; ic++) begin
      for (int k = 0; k < c_K; k++) begin
        idx = op * c_S + k - c_P;
        if (idx < 0 || idx >= c_L) x = 0;
        else x = $signed(in_mem[ic * c_L + idx]);
        w = $signed(wmem[(oc * c_C + ic) * c_K + k]);
        acc = acc + longint'(x * w);
      end
    end
    b = longint'($signed(bmem[oc]));
    y = (acc >>> 7) + b;
    if (c_act != 0 && y < 0) y = y >>> 3;
    if (y > 32767) return 16'h7FFF;
    else if (y < -32768) return 16'h8000;
    else return 16'(y);
  endfunction

  task automatic set_cfg(input int l, input int c, input int m, input int k,
                         input int s, input int p, input int act);
    c_L = l; c_C = c; c_M = m; c_K = k; c_S = s; c_P = p; c_act = act;
    c_O = (s == 1 || s == 2) ? ((l + 2 * p - k) / s + 1) : 0;
  endtask

  task automatic do_start();
    cfg_frame_len = 7'(c_L); cfg_in_ch = 4'(c_C); cfg_out_ch = 5'(c_M);
    cfg_kernel = 3'(c_K); cfg_stride = 2'(c_S); cfg_padding = 3'(c_P);
    cfg_act = 1'(c_act);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_frame(input int gaps, output int to);
    int i, cyc;
    logic hs;
    i = 0; cyc = 0;
    while (i < c_C * c_L && cyc < 5000) begin
      if (gaps != 0 && $urandom_range(0, 2) == 0) s_valid = 1'b0;
      else s_valid = 1'b1;
      s_data = in_mem[i];
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    s_valid = 1'b0;
    to = (i < c_C * c_L) ? 1 : 0;
  endtask

  task automatic collect(input int n, input int rnd, output int stall_err, output int to);
    int got, cyc;
    logic prev_stall;
    logic [15:0] prev_data;
    got = 0; cyc = 0; stall_err = 0; prev_stall = 1'b0; prev_data = 16'd0;
    out_q.delete(); last_q.delete();
    while (got < n && cyc < 20000) begin
      m_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid === 1'b1 && m_ready) begin
        out_q.push_back(m_data);
        last_q.push_back(m_last);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    to = (got < n) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
    checks++; if (weight_addr !== 10'd0) begin errors++; $display("FAIL reset_weight_addr: got %0d want 0", weight_addr); end
    checks++; if (bias_addr !== 4'd0) begin errors++; $display("FAIL reset_bias_addr: got %0d want 0", bias_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4];
    int d0, to, se;
    exp_d[0] = 16'h0100; exp_d[1] = 16'h0180; exp_d[2] = 16'h0180; exp_d[3] = 16'h0100;
    set_cfg(4, 1, 1, 3, 1, 1, 0);
    for (int i = 0; i < 4; i++) in_mem[i] = 16'h0100;
    for (int i = 0; i < 3; i++) wmem[i] = 8'h40;
    bmem[0] = 16'h0000;
    d0 = done_total;
    do_start();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL basic_cfg_err: got %b want 0", cfg_err); end
    load_frame(0, to);
    collect(4, 0, se, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL basic_timeout: got %0d samples want 4", out_q.size()); end
    for (int j = 0; j < out_q.size() && j < 4; j++) begin
      checks++;
      if (out_q[j] !== exp_d[j]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", j, out_q[j], exp_d[j]); end
      checks++;
      if (last_q[j] !== (j == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", j, last_q[j], (j == 3)); end
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_total - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic fill_multi();
    for (int i = 0; i < 16; i++) in_mem[i] = 16'(((i * 173) % 1024) - 512);
    for (int i = 0; i < 18; i++) wmem[i] = 8'((i * 29 + 11) % 256);
    for (int i = 0; i < 3; i++) bmem[i] = 16'(i * 64 - 100);
  endtask

  task automatic test_multi(input int stress);
    int to, se, n, d0;
    set_cfg(8, 2, 3, 3, 2, 1, 1);
    fill_multi();
    n = c_M * c_O;
    d0 = done_total;
    do_start();
    load_frame(stress, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL multi%0d_load_timeout: stalled", stress); end
    collect(n, stress, se, to);
    checks++; if (out_q.size() !== 12) begin errors++; $display("FAIL multi%0d_count: got %0d want 12", stress, out_q.size()); end
    checks++; if (se !== 0) begin errors++; $display("FAIL multi%0d_stall_hold: got %0d changes want 0", stress, se); end
    for (int j = 0; j < out_q.size(); j++) begin
      checks++;
      if (out_q[j] !== model_out(j / c_O, j % c_O)) begin
        errors++; $display("FAIL multi%0d_data[%0d]: got %h want %h", stress, j, out_q[j], model_out(j / c_O, j % c_O));
      end
      checks++;
      if (last_q[j] !== (j == n - 1)) begin errors++; $display("FAIL multi%0d_last[%0d]: got %b want %b", stress, j, last_q[j], (j == n - 1)); end
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL multi%0d_extra_sample: m_valid got %b want 0", stress, m_valid); end
    checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL multi%0d_done_pulses: got %0d want 1", stress, done_total - d0); end
  endtask

  task automatic test_act();
    int to, se;
    logic [15:0] exp_d [2];
    exp_d[0] = 16'hFFE0; exp_d[1] = 16'hFF00;
    in_mem[0] = 16'h0100; wmem[0] = 8'h80; bmem[0] = 16'h0000;
    for (int a = 0; a < 2; a++) begin
      set_cfg(1, 1, 1, 1, 1, 0, 1 - a);
      do_start();
      load_frame(0, to);
      collect(1, 0, se, to);
      checks++;
      if (to !== 0 || out_q[0] !== exp_d[a]) begin
        errors++; $display("FAIL act%0d_data: got %h want %h", 1 - a, (to != 0) ? 16'hxxxx : out_q[0], exp_d[a]);
      end
      repeat (3) @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    int to, se;
    logic [7:0] wv [2];
    logic [15:0] exp_d [2];
    wv[0] = 8'h7F; wv[1] = 8'h80; exp_d[0] = 16'h7FFF; exp_d[1] = 16'h8000;
    for (int i = 0; i < 56; i++) in_mem[i] = 16'h7FFF;
    bmem[0] = 16'h0000;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 56; i++) wmem[i] = wv[t];
      set_cfg(7, 8, 1, 7, 1, 0, 0);
      do_start();
      load_frame(0, to);
      collect(1, 0, se, to);
      checks++;
      if (to !== 0 || out_q[0] !== exp_d[t]) begin
        errors++; $display("FAIL sat%0d_data: got %h want %h", t, (to != 0) ? 16'hxxxx : out_q[0], exp_d[t]);
      end
      checks++;
      if (to !== 0 || last_q[0] !== 1'b1) begin errors++; $display("FAIL sat%0d_last: got %b want 1", t, (to != 0) ? 1'bx : last_q[0]); end
      repeat (3) @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_stride();
    int sr0;
    set_cfg(8, 1, 1, 3, 3, 1, 0);
    sr0 = s_ready_total;
    do_start();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL stride3_cfg_err: got %b want 1", cfg_err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stride3_done_early: got %b want 0", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stride3_done_pulse: got %b want 1", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stride3_done_width: got %b want 0", done); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL stride3_cfg_err_sticky: got %b want 1", cfg_err); end
    repeat (2) @(posedge clk); #1;
    checks++; if (s_ready_total - sr0 !== 0) begin errors++; $display("FAIL stride3_s_ready: got %0d cycles want 0", s_ready_total - sr0); end
  endtask

  task automatic test_reset_mid_mac();
    int to, se;
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0100; exp_d[1] = 16'h0180; exp_d[2] = 16'h0180; exp_d[3] = 16'h0100;
    set_cfg(8, 2, 3, 3, 2, 1, 1);
    fill_multi();
    do_start();
    load_frame(0, to);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_cfg(4, 1, 1, 3, 1, 1, 0);
    for (int i = 0; i < 4; i++) in_mem[i] = 16'h0100;
    for (int i = 0; i < 3; i++) wmem[i] = 8'h40;
    bmem[0] = 16'h0000;
    do_start();
    load_frame(0, to);
    collect(4, 0, se, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL midrst_rerun_timeout: got %0d samples want 4", out_q.size()); end
    for (int j = 0; j < out_q.size() && j < 4; j++) begin
      checks++;
      if (out_q[j] !== exp_d[j]) begin errors++; $display("FAIL midrst_rerun[%0d]: got %h want %h", j, out_q[j], exp_d[j]); end
    end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL midrst_cfg_err: got %b want 0", cfg_err); end
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 896; i++) wmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) bmem[i] = 16'h0000;
    for (int i = 0; i < 512; i++) in_mem[i] = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_multi(0);
    test_act();
    test_saturation();
    test_multi(1);
    test_bad_stride();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
